cursor_step_ctrl: RTL

Converts the four level-sensitive, already-debounced arrow buttons into rate-controlled single-cycle step pulses for the corner-adjust UI that sits after the accelerometer LUT. It sits between the button debouncers and the corner-adjust logic, which moves the selected corner by one pixel per clock that a direction input is high. A tap yields exactly one step; a held button auto-repeats after an initial delay and accelerates after a set number of repeats.

---
 rtl/cursor_ui_pkg.sv | 33 +++
 rtl/ms_tick_gen.sv | 32 +++
 rtl/cursor_step_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cursor_ui_pkg.sv
`default_nettype none
// ============================================================================
// cursor_ui_pkg : direction codes, FSM state encoding and button priority
// Revision: 1.0  initial release
// ============================================================================
package cursor_ui_pkg;

   localparam logic [1:0] DIR_DOWN  = 2'd0;
   localparam logic [1:0] DIR_UP    = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_SLOW = 2'd2,
      S_FAST = 2'd3
   } state_t;

   // btn is indexed by direction code; order matches the consumer's if/else chain
   function automatic logic [1:0] prio_dir(input logic [3:0] btn);
      if (btn[DIR_DOWN])
         return DIR_DOWN;
      else if (btn[DIR_UP])
         return DIR_UP;
      else if (btn[DIR_LEFT])
         return DIR_LEFT;
      else
         return DIR_RIGHT;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ms_tick_gen.sv
`default_nettype none
// ============================================================================
// ms_tick_gen : prescaler producing a one-cycle tick every TICK_DIV clocks
// Revision: 1.0  initial release
// ============================================================================
module ms_tick_gen #(
   parameter int TICK_DIV = 65000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clear || (cnt == LAST))
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/cursor_step_ctrl.sv
`default_nettype none
// ============================================================================
// cursor_step_ctrl : arrow buttons to rate-controlled step pulses with repeat
// Revision: 1.0  initial release
// ============================================================================
module cursor_step_ctrl
   import cursor_ui_pkg::*;
#(
   parameter int TICK_DIV   = 65000,
   parameter int HOLD_MS    = 400,
   parameter int REPEAT_MS  = 100,
   parameter int FAST_MS    = 20,
   parameter int FAST_AFTER = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       up,
   input  logic       down,
   input  logic       left,
   input  logic       right,
   output logic       up_step,
   output logic       down_step,
   output logic       left_step,
   output logic       right_step,
   output logic [1:0] held_dir,
   output logic       repeating
);

   localparam int MS_MAX = (HOLD_MS > REPEAT_MS) ?
                           ((HOLD_MS > FAST_MS) ? HOLD_MS : FAST_MS) :
                           ((REPEAT_MS > FAST_MS) ? REPEAT_MS : FAST_MS);
   localparam int MSW = (MS_MAX > 0) ? $clog2(MS_MAX + 1) : 1;
   localparam int RCW = (FAST_AFTER > 0) ? $clog2(FAST_AFTER + 1) : 1;

   localparam logic [MSW-1:0] HOLD_END   = MSW'(HOLD_MS);
   localparam logic [MSW-1:0] REPEAT_END = MSW'(REPEAT_MS);
   localparam logic [MSW-1:0] FAST_END   = MSW'(FAST_MS);
   localparam logic [RCW-1:0] RC_END     = RCW'(FAST_AFTER);

   if ((TICK_DIV <= 0) || (HOLD_MS <= 0) || (REPEAT_MS <= 0) || (FAST_MS <= 0)) begin : g_param_check
      $fatal(1, "cursor_step_ctrl: TICK_DIV, HOLD_MS, REPEAT_MS and FAST_MS must be nonzero");
   end

   state_t          state, state_nx;
   logic [1:0]      dir_nx, press_dir;
   logic [3:0]      btn, step_q, step_nx;
   logic [MSW-1:0]  ms_cnt, ms_inc, ms_nx;
   logic [RCW-1:0]  rep_cnt, rep_inc, rep_nx;
   logic            tick, tick_clr, held_btn;

   ms_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (tick_clr),
      .tick  (tick)
   );

   assign btn       = {right, left, up, down};
   assign press_dir = prio_dir(btn);
   assign held_btn  = btn[held_dir];
   assign ms_inc    = ms_cnt + MSW'(tick);
   assign rep_inc   = (rep_cnt == RC_END) ? rep_cnt : rep_cnt + 1'b1;

   always_comb begin
      state_nx = state;
      dir_nx   = held_dir;
      step_nx  = '0;
      ms_nx    = ms_inc;
      rep_nx   = rep_cnt;
      tick_clr = 1'b0;
      // Disable and release both win over a repeat that would fire this cycle
      if (!enable || ((state != S_IDLE) && !held_btn)) begin
         state_nx = S_IDLE;
         ms_nx    = '0;
         tick_clr = 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               ms_nx    = '0;
               tick_clr = 1'b1;
               if (|btn) begin
                  dir_nx            = press_dir;
                  step_nx[press_dir] = 1'b1;
                  state_nx          = S_HOLD;
               end
            end
            S_HOLD: begin
               if (tick && (ms_inc == HOLD_END)) begin
                  step_nx[held_dir] = 1'b1;
                  ms_nx             = '0;
                  tick_clr          = 1'b1;
                  rep_nx            = '0;
                  state_nx          = (FAST_AFTER == 0) ? S_FAST : S_SLOW;
               end
            end
            S_SLOW: begin
               if (tick && (ms_inc == REPEAT_END)) begin
                  step_nx[held_dir] = 1'b1;
                  ms_nx             = '0;
                  tick_clr          = 1'b1;
                  rep_nx            = rep_inc;
                  if (rep_inc == RC_END)
                     state_nx = S_FAST;
               end
            end
            S_FAST: begin
               if (tick && (ms_inc == FAST_END)) begin
                  step_nx[held_dir] = 1'b1;
                  ms_nx             = '0;
                  tick_clr          = 1'b1;
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         held_dir <= DIR_DOWN;
         step_q   <= '0;
         ms_cnt   <= '0;
         rep_cnt  <= '0;
      end else begin
         state    <= state_nx;
         held_dir <= dir_nx;
         step_q   <= step_nx;
         ms_cnt   <= ms_nx;
         rep_cnt  <= rep_nx;
      end
   end

   assign down_step  = step_q[DIR_DOWN];
   assign up_step    = step_q[DIR_UP];
   assign left_step  = step_q[DIR_LEFT];
   assign right_step = step_q[DIR_RIGHT];
   assign repeating  = (state == S_SLOW) || (state == S_FAST);

endmodule
`default_nettype wire
